// File: rtl/crank_decoder.sv
`timescale 1ns/1ps
// Missing-tooth crank wheel decoder: per-tooth trigger + tooth index, sync status, diagnostics.
// trigger follows a crank_in rise by three clk edges; free-running, no backpressure.
module crank_decoder #(
  parameter int TEETH_TOTAL   = 60,
  parameter int TEETH_MISSING = 2,
  parameter int MIN_PERIOD    = 100,
  parameter int STALL_CYCLES  = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        crank_in,
  output logic        trigger,
  output logic [15:0] eng_phase,
  output logic        synced,
  output logic [31:0] tooth_period,
  output logic [7:0]  sync_loss_cnt
);

  localparam logic [15:0] LAST    = 16'(TEETH_TOTAL - TEETH_MISSING - 1);
  localparam logic [31:0] MIN_P   = 32'(MIN_PERIOD);
  localparam logic [31:0] STALL_P = 32'(STALL_CYCLES);
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_STOPPED,
    ST_HUNT,
    ST_SYNCED
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        s1;
  logic        s2;
  logic        s3;
  logic        raw_edge;
  logic        accept;
  logic        stall;
  logic        gap;

  logic [31:0] cnt;
  logic [31:0] cnt_nxt;
  logic [31:0] prev_period;
  logic [31:0] prev_period_nxt;
  logic        prev_valid;
  logic        prev_valid_nxt;
  logic [33:0] period_x2;
  logic [33:0] prev_x3;

  logic        trigger_nxt;
  logic [15:0] eng_phase_nxt;
  logic [31:0] tooth_period_nxt;
  logic [7:0]  sync_loss_nxt;
  logic        store_prev;
  logic        lose_sync;

  // crank_in is asynchronous: two flops for metastability, a third for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= crank_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign raw_edge  = s2 & ~s3;
  assign accept    = raw_edge && (cnt >= MIN_P);
  assign stall     = (cnt >= STALL_P) && (state != ST_STOPPED);

  // 34-bit compare so 3*prev_period cannot wrap for any 32-bit period
  assign period_x2 = {1'b0, cnt, 1'b0};
  assign prev_x3   = {2'b00, prev_period} + {1'b0, prev_period, 1'b0};
  assign gap       = prev_valid && (period_x2 > prev_x3);

  assign synced    = (state == ST_SYNCED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_STOPPED;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    trigger_nxt      = 1'b0;
    eng_phase_nxt    = eng_phase;
    tooth_period_nxt = tooth_period;
    prev_period_nxt  = prev_period;
    prev_valid_nxt   = prev_valid;
    store_prev       = 1'b0;
    lose_sync        = 1'b0;
    cnt_nxt          = (cnt == CNT_MAX) ? cnt : cnt + 32'd1;

    if (accept) begin
      cnt_nxt          = 32'd1;
      tooth_period_nxt = cnt;
      unique case (state)
        ST_STOPPED: begin
          state_nxt = ST_HUNT;
        end
        ST_HUNT: begin
          if (gap) begin
            state_nxt     = ST_SYNCED;
            eng_phase_nxt = 16'd0;
            trigger_nxt   = 1'b1;
          end else begin
            store_prev = 1'b1;
          end
        end
        ST_SYNCED: begin
          if (gap) begin
            if (eng_phase == LAST) begin
              eng_phase_nxt = 16'd0;
              trigger_nxt   = 1'b1;
            end else begin
              lose_sync = 1'b1;
            end
          end else begin
            store_prev = 1'b1;
            if (eng_phase < LAST) begin
              eng_phase_nxt = eng_phase + 16'd1;
              trigger_nxt   = 1'b1;
            end else begin
              lose_sync = 1'b1;
            end
          end
        end
        default: begin
          state_nxt = ST_STOPPED;
        end
      endcase
      if (lose_sync) begin
        state_nxt = ST_HUNT;
      end
    end else if (stall) begin
      // an edge in the same cycle takes priority, so this branch only sees a quiet wheel
      state_nxt      = ST_STOPPED;
      eng_phase_nxt  = 16'd0;
      prev_valid_nxt = 1'b0;
      lose_sync      = (state == ST_SYNCED);
    end

    if (store_prev) begin
      prev_period_nxt = cnt;
      prev_valid_nxt  = 1'b1;
    end

    sync_loss_nxt = (lose_sync && (sync_loss_cnt != 8'hFF)) ? sync_loss_cnt + 8'd1 : sync_loss_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= 32'd0;
      prev_period   <= 32'd0;
      prev_valid    <= 1'b0;
      trigger       <= 1'b0;
      eng_phase     <= 16'd0;
      tooth_period  <= 32'd0;
      sync_loss_cnt <= 8'd0;
    end else begin
      cnt           <= cnt_nxt;
      prev_period   <= prev_period_nxt;
      prev_valid    <= prev_valid_nxt;
      trigger       <= trigger_nxt;
      eng_phase     <= eng_phase_nxt;
      tooth_period  <= tooth_period_nxt;
      sync_loss_cnt <= sync_loss_nxt;
    end
  end

endmodule

// File: tb/tb_crank_decoder.sv
`timescale 1ns/1ps
// Drives a scaled 60-2 wheel (directed scenarios plus random jitter/glitch/chaos phases)
// and compares every cycle against a behavioural model of the decoder.
module tb_crank_decoder;

  localparam int TT    = 60;
  localparam int TM    = 2;
  localparam int MINP  = 30;
  localparam int STALL = 600;
  localparam int LASTP = TT - TM - 1;
  localparam int P0    = 60;
  localparam int HI    = 10;

  localparam int M_STOP = 0;
  localparam int M_HUNT = 1;
  localparam int M_SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        crank_in = 1'b0;
  logic        trigger;
  logic [15:0] eng_phase;
  logic        synced;
  logic [31:0] tooth_period;
  logic [7:0]  sync_loss_cnt;

  crank_decoder #(
    .TEETH_TOTAL  (TT),
    .TEETH_MISSING(TM),
    .MIN_PERIOD   (MINP),
    .STALL_CYCLES (STALL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .crank_in     (crank_in),
    .trigger      (trigger),
    .eng_phase    (eng_phase),
    .synced       (synced),
    .tooth_period (tooth_period),
    .sync_loss_cnt(sync_loss_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_mode = M_STOP;
  longint      m_age = 0;
  longint      m_prev = 0;
  bit          m_prev_ok = 1'b0;
  bit          m_trig = 1'b0;
  int          m_phase = 0;
  logic [31:0] m_period = 32'd0;
  int          m_loss = 0;
  bit          hist [3];
  bit          m_raw;
  bit          m_gap;
  bit          m_lose;
  longint      m_p;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_STOP; m_age = 0; m_prev = 0; m_prev_ok = 1'b0;
      m_trig = 1'b0; m_phase = 0; m_period = 32'd0; m_loss = 0;
      hist[0] = 1'b0; hist[1] = 1'b0; hist[2] = 1'b0;
    end else begin
      // a rise is seen once the sample from two edges ago is high and the one before it low
      m_raw  = hist[1] && !hist[2];
      m_trig = 1'b0;
      m_lose = 1'b0;
      if (m_raw && m_age >= MINP) begin
        m_p      = m_age;
        m_period = m_p[31:0];
        m_age    = 1;
        m_gap    = m_prev_ok && (2 * m_p > 3 * m_prev);
        if (m_mode == M_STOP) begin
          m_mode = M_HUNT;
        end else begin
          if (!m_gap) begin m_prev = m_p; m_prev_ok = 1'b1; end
          if (m_mode == M_HUNT) begin
            if (m_gap) begin m_mode = M_SYNC; m_phase = 0; m_trig = 1'b1; end
          end else if (m_gap == (m_phase == LASTP)) begin
            m_phase = m_gap ? 0 : m_phase + 1;
            m_trig  = 1'b1;
          end else begin
            m_mode = M_HUNT;
            m_lose = 1'b1;
          end
        end
      end else begin
        if (m_age >= STALL && m_mode != M_STOP) begin
          m_lose = (m_mode == M_SYNC);
          m_mode = M_STOP; m_phase = 0; m_prev_ok = 1'b0;
        end
        if (m_age < 64'hFFFF_FFFF) m_age = m_age + 1;
      end
      if (m_lose && m_loss < 255) m_loss = m_loss + 1;
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = crank_in;
    end
  end

  // ---------------- checking and stimulus ----------------
  int tests = 0;
  int fails = 0;
  int trig_seen = 0;
  int trig0_seen = 0;
  int pos = 0;

  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      tests++;
      if (trigger !== m_trig || eng_phase !== 16'(m_phase) || synced !== (m_mode == M_SYNC) ||
          tooth_period !== m_period || sync_loss_cnt !== 8'(m_loss)) begin
        fails++;
        $display("FAIL model_cmp t=%0t got trig=%0b ph=%0d sync=%0b per=%0d loss=%0d want trig=%0b ph=%0d sync=%0b per=%0d loss=%0d",
                 $time, trigger, eng_phase, synced, tooth_period, sync_loss_cnt,
                 m_trig, m_phase, (m_mode == M_SYNC), m_period, m_loss);
      end
      if (trigger === 1'b1) begin
        trig_seen++;
        if (eng_phase == 16'd0) trig0_seen++;
      end
    end
  endtask

  task automatic check(input string name, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask

  task automatic pulse(input int spacing, input int hi);
    for (int i = 0; i < spacing; i++) begin
      tick();
      crank_in = (i < hi);
    end
  endtask

  task automatic pulse_glitch(input int spacing);
    for (int i = 0; i < spacing; i++) begin
      tick();
      crank_in = (i < HI) || (i >= 24 && i < 27);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      crank_in = 1'b0;
    end
  endtask

  task automatic teeth(input int n, input int p);
    for (int k = 0; k < n; k++) begin
      pulse((pos == LASTP) ? 3 * p : p, HI);
      pos = (pos == LASTP) ? 0 : pos + 1;
    end
  endtask

  task automatic to_pos(input int target, input int p);
    while (pos != target) teeth(1, p);
  endtask

  initial begin
    int p;
    int sp;
    int hi;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    idle(40);
    check("rst_trigger", trigger, 0);
    check("rst_phase", eng_phase, 0);
    check("rst_synced", synced, 0);
    check("rst_period", tooth_period, 0);
    check("rst_loss", sync_loss_cnt, 0);

    // mid-wheel start, first gap gives sync, then one full revolution
    pos = $urandom_range(5, 50);
    to_pos(0, P0);
    teeth(1, P0);
    check("sync_first_gap", synced, 1);
    check("sync_phase0", eng_phase, 0);
    check("gap_period", tooth_period, 180);
    trig_seen = 0; trig0_seen = 0;
    teeth(58, P0);
    check("rev_triggers", trig_seen, 58);
    check("rev_zero_phase_triggers", trig0_seen, 1);
    check("rev_gap_period", tooth_period, 180);
    teeth(1, P0);
    check("tooth1_period", tooth_period, 60);
    check("tooth1_phase", eng_phase, 1);

    // glitch inside MIN_PERIOD of a tooth is ignored
    to_pos(10, P0);
    pulse_glitch(P0);
    pos = 11;
    check("glitch_phase", eng_phase, 10);
    check("glitch_period", tooth_period, 60);
    teeth(1, P0);
    check("after_glitch_period", tooth_period, 60);
    check("after_glitch_phase", eng_phase, 11);
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        pulse_glitch((pos == LASTP) ? 3 * P0 : P0);
        pos = (pos == LASTP) ? 0 : pos + 1;
      end else begin
        teeth(1, P0);
      end
    end
    check("glitch_loss", sync_loss_cnt, 0);

    // extra teeth inside the gap: missing gap at phase 57 loses sync
    to_pos(LASTP, P0);
    pulse(P0, HI);
    trig_seen = 0;
    pulse(P0, HI);
    check("extra_no_trigger", trig_seen, 0);
    check("extra_synced", synced, 0);
    check("extra_loss", sync_loss_cnt, 1);
    check("extra_phase_hold", eng_phase, 57);
    pulse(P0, HI);
    pos = 0;
    teeth(1, P0);
    to_pos(0, P0);
    teeth(1, P0);
    check("resync_synced", synced, 1);
    check("resync_phase", eng_phase, 0);

    // wheel stops after phase 20
    to_pos(20, P0);
    pulse(40, HI);
    check("pre_stall_synced", synced, 1);
    check("pre_stall_phase", eng_phase, 20);
    idle(STALL);
    check("stall_synced", synced, 0);
    check("stall_phase", eng_phase, 0);
    check("stall_loss", sync_loss_cnt, 2);
    pos = 21;
    teeth(3, P0);
    check("restart_hunting", synced, 0);
    to_pos(0, P0);
    teeth(1, P0);
    check("restart_synced", synced, 1);

    // linear acceleration 60 -> 36 over one revolution
    trig_seen = 0;
    for (int i = 0; i < 58; i++) teeth(1, 60 - (24 * i) / 57);
    check("accel_triggers", trig_seen, 58);
    check("accel_phase", eng_phase, 0);
    check("accel_gap_period", tooth_period, 111);
    check("accel_loss", sync_loss_cnt, 2);

    // asynchronous reset mid-rotation
    to_pos(30, 36);
    teeth(1, 36);
    check("pre_reset_phase", eng_phase, 30);
    tick();
    #3 rst_n = 1'b0;
    #1;
    check("arst_trigger", trigger, 0);
    check("arst_phase", eng_phase, 0);
    check("arst_synced", synced, 0);
    check("arst_period", tooth_period, 0);
    check("arst_loss", sync_loss_cnt, 0);
    repeat (3) tick();
    #2 rst_n = 1'b1;
    to_pos(0, P0);
    teeth(1, P0);
    check("post_reset_synced", synced, 1);
    check("post_reset_phase", eng_phase, 0);
    check("post_reset_loss", sync_loss_cnt, 0);

    // random jitter and glitches on a running wheel
    for (int k = 0; k < 120; k++) begin
      p = $urandom_range(56, 64);
      if ($urandom_range(0, 4) == 0) begin
        pulse_glitch((pos == LASTP) ? 3 * p : p);
        pos = (pos == LASTP) ? 0 : pos + 1;
      end else begin
        teeth(1, p);
      end
    end

    // unstructured edges: noise, early gaps, stalls
    for (int k = 0; k < 50; k++) begin
      sp = ($urandom_range(0, 9) == 0) ? 700 : $urandom_range(2, 260);
      hi = $urandom_range(1, (sp - 1 < 8) ? sp - 1 : 8);
      pulse(sp, hi);
    end
    idle(STALL + 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
